// File: rtl/wr_burst_sched_if.sv
// wr_burst_sched_if: groups the FIFO read-side and AXI write-burst master signals of the scheduler.
interface wr_burst_sched_if #(
  parameter int FIFO_CNT_WIDTH = 10,
  parameter int ADDR_WIDTH     = 30
);
  logic                      sched_en;
  logic                      addr_clr;
  logic [FIFO_CNT_WIDTH-1:0] fifo_rd_data_count;
  logic                      fifo_empty;
  logic                      fifo_rd_en;
  logic                      wr_burst_req;
  logic [ADDR_WIDTH-1:0]     wr_burst_addr;
  logic                      wr_burst_ack;
  logic                      wr_data_ready;
  logic                      wr_data_valid;
  logic                      wr_data_last;
  logic                      wr_burst_done;
  logic                      sched_busy;
  modport master (
    input  sched_en, addr_clr, fifo_rd_data_count, fifo_empty,
           wr_burst_ack, wr_data_ready, wr_burst_done,
    output fifo_rd_en, wr_burst_req, wr_burst_addr, wr_data_valid,
           wr_data_last, sched_busy
  );
  modport slave (
    output sched_en, addr_clr, fifo_rd_data_count, fifo_empty,
           wr_burst_ack, wr_data_ready, wr_burst_done,
    input  fifo_rd_en, wr_burst_req, wr_burst_addr, wr_data_valid,
           wr_data_last, sched_busy
  );
endinterface

// File: rtl/wr_burst_sched.sv
// wr_burst_sched: starts a fixed-length write burst once the FIFO holds a full burst,
// walks a wrapping address window and gates FIFO pops with the master's data-ready.
module wr_burst_sched #(
  parameter int FIFO_CNT_WIDTH = 10,
  parameter int BURST_LEN      = 16,
  parameter int ADDR_WIDTH     = 30,
  parameter int BEAT_BYTES     = 8,
  parameter int ADDR_BEGIN     = 0,
  parameter int ADDR_END       = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  wr_burst_sched_if.master   bus
);
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH:0] INC = (ADDR_WIDTH+1)'(BURST_LEN * BEAT_BYTES);
  localparam logic [ADDR_WIDTH:0] END_X = (ADDR_WIDTH+1)'(ADDR_END);
  localparam logic [ADDR_WIDTH-1:0] BEGIN_A = ADDR_WIDTH'(ADDR_BEGIN);
  typedef enum logic [1:0] {IDLE, REQ, DATA, RESP} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr, addr_nx;
  logic [ADDR_WIDTH:0] addr_inc;
  logic [BW-1:0] beat_cnt, beat_nx;
  logic req, req_nx, clr_pend, clr_pend_nx;
  logic rd_en, valid, last, start;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req      <= 1'b0;
      addr     <= BEGIN_A;
      beat_cnt <= '0;
      clr_pend <= 1'b0;
    end else begin
      state    <= state_nx;
      req      <= req_nx;
      addr     <= addr_nx;
      beat_cnt <= beat_nx;
      clr_pend <= clr_pend_nx;
    end
  end
  assign addr_inc = {1'b0, addr} + INC;
  assign start = bus.sched_en && (32'(bus.fifo_rd_data_count) >= 32'(BURST_LEN));
  always_comb begin
    state_nx    = state;
    req_nx      = req;
    addr_nx     = addr;
    beat_nx     = beat_cnt;
    clr_pend_nx = clr_pend;
    rd_en       = 1'b0;
    valid       = 1'b0;
    last        = 1'b0;
    case (state)
      IDLE: begin
        addr_nx  = bus.addr_clr ? BEGIN_A : addr;
        state_nx = start ? REQ : IDLE;
        req_nx   = start;
      end
      REQ: begin
        clr_pend_nx = clr_pend || bus.addr_clr;
        if (bus.wr_burst_ack) begin
          req_nx   = 1'b0;
          beat_nx  = '0;
          state_nx = DATA;
        end
      end
      DATA: begin
        clr_pend_nx = clr_pend || bus.addr_clr;
        valid       = !bus.fifo_empty;
        rd_en       = bus.wr_data_ready && !bus.fifo_empty;
        last        = (beat_cnt == LAST_BEAT) && valid;
        if (rd_en) begin
          beat_nx  = (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BW'(1);
          state_nx = (beat_cnt == LAST_BEAT) ? RESP : DATA;
        end
      end
      RESP: begin
        clr_pend_nx = clr_pend || bus.addr_clr;
        if (bus.wr_burst_done) begin
          // a pending or coincident clear beats the normal advance
          addr_nx     = (clr_pend || bus.addr_clr || (addr_inc + INC > END_X))
                        ? BEGIN_A : addr_inc[ADDR_WIDTH-1:0];
          clr_pend_nx = 1'b0;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  assign bus.fifo_rd_en    = rd_en;
  assign bus.wr_data_valid = valid;
  assign bus.wr_data_last  = last;
  assign bus.wr_burst_req  = req;
  assign bus.wr_burst_addr = addr;
  assign bus.sched_busy    = state != IDLE;
endmodule

// File: tb/tb_wr_burst_sched.sv
// tb_wr_burst_sched: directed bursts through the scheduler with a queue of expected burst
// addresses and a small address-window model.
module tb_wr_burst_sched;
  localparam int BL = 16;
  localparam int BB = 8;
  localparam int AE = 512;
  localparam int AW = 30;
  localparam int CW = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  wr_burst_sched_if #(.FIFO_CNT_WIDTH(CW), .ADDR_WIDTH(AW)) bus();
  wr_burst_sched #(
    .FIFO_CNT_WIDTH(CW), .BURST_LEN(BL), .ADDR_WIDTH(AW),
    .BEAT_BYTES(BB), .ADDR_BEGIN(0), .ADDR_END(AE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master)
  );
  int tests = 0;
  int fails = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr = '0;
  bit pend = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic model_done(input bit clr);
    int n;
    n = int'(exp_addr) + BL * BB;
    exp_addr = (pend || clr || (n + BL * BB > AE)) ? '0 : AW'(n);
    pend = 1'b0;
  endtask
  task automatic do_burst(input int ack_dly, input bit stall, input bit clr_data,
                          input bit clr_done, input int rst_at);
    int w, pops, stl;
    logic [AW-1:0] a;
    exp_q.push_back(exp_addr);
    bus.fifo_rd_data_count = CW'(BL);
    w = 0;
    do begin tick; w++; end while (!bus.wr_burst_req && w < 4);
    chk("req_latency", w, 1);
    a = exp_q.pop_front();
    chk("burst_addr", bus.wr_burst_addr, a);
    bus.fifo_rd_data_count = '0;
    repeat (ack_dly) begin
      tick;
      chk("req_hold", bus.wr_burst_req, 1);
      chk("addr_hold", bus.wr_burst_addr, a);
    end
    bus.wr_burst_ack = 1'b1;
    tick;
    bus.wr_burst_ack = 1'b0;
    chk("req_drop", bus.wr_burst_req, 0);
    chk("busy_data", bus.sched_busy, 1);
    bus.wr_data_ready = 1'b1;
    pops = 0; stl = 0; w = 0;
    while (pops < BL && w < 100) begin
      if (rst_at >= 0 && pops == rst_at) begin
        bus.fifo_empty = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_req", bus.wr_burst_req, 0);
        chk("rst_rd_en", bus.fifo_rd_en, 0);
        chk("rst_busy", bus.sched_busy, 0);
        chk("rst_addr", bus.wr_burst_addr, 0);
        exp_addr = '0;
        pend = 1'b0;
        bus.wr_data_ready = 1'b0;
        tick;
        rst_n = 1'b1;
        return;
      end
      bus.fifo_empty = stall && pops == 7 && stl < 3;
      if (bus.fifo_empty) stl++;
      bus.addr_clr = clr_data && pops == 3;
      #1;
      chk("rd_en", bus.fifo_rd_en, !bus.fifo_empty);
      chk("valid", bus.wr_data_valid, !bus.fifo_empty);
      chk("last", bus.wr_data_last, pops == BL - 1 && !bus.fifo_empty);
      if (bus.fifo_rd_en) pops++;
      tick;
      w++;
    end
    bus.addr_clr = 1'b0;
    bus.fifo_empty = 1'b0;
    if (clr_data) pend = 1'b1;
    chk("pop_total", pops, BL);
    #1;
    chk("resp_no_pop", bus.fifo_rd_en, 0);
    chk("busy_resp", bus.sched_busy, 1);
    tick;
    chk("resp_wait", bus.fifo_rd_en, 0);
    bus.wr_burst_done = 1'b1;
    bus.addr_clr = clr_done;
    tick;
    bus.wr_burst_done = 1'b0;
    bus.addr_clr = 1'b0;
    model_done(clr_done);
    chk("busy_idle", bus.sched_busy, 0);
    chk("addr_update", bus.wr_burst_addr, exp_addr);
    bus.wr_data_ready = 1'b0;
  endtask
  initial begin
    bus.sched_en = 1'b0;
    bus.addr_clr = 1'b0;
    bus.fifo_rd_data_count = '0;
    bus.fifo_empty = 1'b0;
    bus.wr_burst_ack = 1'b0;
    bus.wr_data_ready = 1'b1;
    bus.wr_burst_done = 1'b0;
    repeat (2) tick;
    chk("reset_req", bus.wr_burst_req, 0);
    chk("reset_addr", bus.wr_burst_addr, 0);
    chk("reset_busy", bus.sched_busy, 0);
    chk("reset_rd_en", bus.fifo_rd_en, 0);
    chk("reset_valid", bus.wr_data_valid, 0);
    chk("reset_last", bus.wr_data_last, 0);
    rst_n = 1'b1;
    bus.wr_data_ready = 1'b0;
    bus.sched_en = 1'b1;
    for (int c = 0; c < BL; c++) begin
      bus.fifo_rd_data_count = CW'(c);
      tick;
      chk("below_burst", bus.wr_burst_req, 0);
    end
    do_burst(5, 0, 0, 0, -1);
    bus.wr_burst_ack = 1'b1;
    bus.wr_burst_done = 1'b1;
    tick;
    bus.wr_burst_ack = 1'b0;
    bus.wr_burst_done = 1'b0;
    chk("stray_busy", bus.sched_busy, 0);
    chk("stray_req", bus.wr_burst_req, 0);
    chk("stray_addr", bus.wr_burst_addr, exp_addr);
    do_burst(0, 1, 0, 0, -1);
    do_burst(1, 0, 0, 0, -1);
    do_burst(0, 0, 0, 0, -1);
    do_burst(2, 0, 0, 0, -1);
    do_burst(0, 0, 0, 0, -1);
    do_burst(0, 0, 1, 0, -1);
    do_burst(0, 0, 0, 1, -1);
    do_burst(0, 0, 0, 0, -1);
    do_burst(0, 0, 0, 0, 5);
    do_burst(0, 0, 0, 0, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
